oneshot_scheduler: RTL and testbench

- Shares one monostable pulse resource among NUM_REQ requesters; each requester asks for a one-shot pulse of its own programmable width.
- Captures trigger edges into pending flags and arbitrates round-robin. Drives a single pulse output of exactly the granted width, then enforces a guard gap before the next pulse.
- Sits between trigger sources (buttons, timers, FSMs) and the shared pulse line; it replaces per-source one-shots when only one pulse line exists.

---
 rtl/oneshot_pkg.sv | 18 +
 rtl/oneshot_scheduler_rr_pick.sv | 35 +++
 rtl/oneshot_scheduler.sv | 131 +++++++++++++
 tb/tb_oneshot_scheduler.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/oneshot_pkg.sv
// Shared types and sizing helpers for the one-shot pulse scheduler.
package oneshot_pkg;

  localparam int STATE_W   = 2;
  localparam int MIN_CNT_W = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GUARD = 2'd2
  } state_t;

  // The shared counter times both pulse widths and the guard gap (up to 15).
  function automatic int cnt_width(input int width_w);
    return (width_w > MIN_CNT_W) ? width_w : MIN_CNT_W;
  endfunction

endpackage

// File: rtl/oneshot_scheduler_rr_pick.sv
// Combinational round-robin picker: first set pending bit at or above ptr, with wrap.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] pending,
  input  logic [IDX_W-1:0]   ptr,
  output logic               valid,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   index
);

  function automatic logic [IDX_W-1:0] wrap(input logic [IDX_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return IDX_W'(sum);
  endfunction

  always_comb begin
    // NOTE: every output gets a default before the search so no path leaves a latch.
    valid  = 1'b0;
    onehot = '0;
    index  = '0;
    // Walk from the farthest offset down so the nearest candidate is the last writer.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (pending[wrap(ptr, k)]) begin
        valid = 1'b1;
        index = wrap(ptr, k);
      end
    end
    if (valid) onehot[index] = 1'b1;
  end

endmodule

// File: rtl/oneshot_scheduler.sv
// Shares one pulse line among NUM_REQ requesters: edge capture, round-robin
// arbitration, exact-width pulse, then a forced low guard gap.
module oneshot_scheduler
  import oneshot_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH_W = 8,
  parameter int GUARD   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH_W-1:0] width,
  output logic                       pulse,
  output logic [NUM_REQ-1:0]         grant,
  output logic [NUM_REQ-1:0]         done,
  output logic                       busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = cnt_width(WIDTH_W);

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t GUARD_LOAD = cnt_t'((GUARD > 0) ? GUARD - 1 : 0);
  localparam cnt_t CNT_ONE    = cnt_t'(1);

  state_t             state;
  cnt_t               cnt;
  logic [NUM_REQ-1:0] req_q;
  logic [NUM_REQ-1:0] pending;
  logic [IDX_W-1:0]   ptr;

  logic [NUM_REQ-1:0] rise;
  logic               pick_valid;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0]   pick_idx;
  logic [WIDTH_W-1:0] sel_width;
  logic [IDX_W-1:0]   ptr_next;
  logic               take;
  logic [NUM_REQ-1:0] pending_clr;

  assign rise = req & ~req_q;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .pending (pending),
    .ptr     (ptr),
    .valid   (pick_valid),
    .onehot  (pick_onehot),
    .index   (pick_idx)
  );

  assign sel_width   = width[int'(pick_idx)*WIDTH_W +: WIDTH_W];
  assign ptr_next    = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
  assign take        = (state == ST_IDLE) && pick_valid;
  assign pending_clr = take ? pick_onehot : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      req_q   <= '0;
      pending <= '0;
      ptr     <= '0;
      pulse   <= 1'b0;
      grant   <= '0;
      done    <= '0;
      busy    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every register see pre-edge values.
      req_q <= req;
      done  <= '0;
      // A rise on the bit being granted this edge wins, so the request survives.
      pending <= (pending & ~pending_clr) | rise;

      unique case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            ptr <= ptr_next;
            if (sel_width == '0) begin
              done <= pick_onehot;
            end else begin
              grant <= pick_onehot;
              pulse <= 1'b1;
              cnt   <= cnt_t'(sel_width) - CNT_ONE;
              state <= ST_PULSE;
              busy  <= 1'b1;
            end
          end
        end

        ST_PULSE: begin
          if (cnt == '0) begin
            pulse <= 1'b0;
            grant <= '0;
            done  <= grant;
            if (GUARD == 0) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              state <= ST_GUARD;
              cnt   <= GUARD_LOAD;
            end
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end

        ST_GUARD: begin
          if (cnt == '0) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          pulse <= 1'b0;
          grant <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oneshot_scheduler.sv
// Scoreboard bench for oneshot_scheduler: directed scenarios push expected
// (owner, width, gap) records; a monitor pops one per done strobe.
module tb_oneshot_scheduler;

  localparam int NUM_REQ = 4;
  localparam int WIDTH_W = 8;
  localparam int GUARD   = 2;
  localparam int GAP     = GUARD + 1;

  typedef struct {
    int id;
    int len;
    int gap;   // -1: gap not checked
  } exp_t;

  logic                       clk;
  logic                       rst;
  logic [NUM_REQ-1:0]         req;
  logic [NUM_REQ*WIDTH_W-1:0] width;
  logic                       pulse;
  logic [NUM_REQ-1:0]         grant;
  logic [NUM_REQ-1:0]         done;
  logic                       busy;

  exp_t sb_q[$];
  int   checks = 0;
  int   passed = 0;
  int   gnt_err = 0;

  oneshot_scheduler #(
    .NUM_REQ (NUM_REQ),
    .WIDTH_W (WIDTH_W),
    .GUARD   (GUARD)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .width (width),
    .pulse (pulse),
    .grant (grant),
    .done  (done),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_w(input int i, input int v);
    width[i*WIDTH_W +: WIDTH_W] = WIDTH_W'(v);
  endtask

  task automatic expect_pulse(input int id, input int len, input int gap);
    exp_t e;
    e.id = id; e.len = len; e.gap = gap;
    sb_q.push_back(e);
  endtask

  task automatic wait_idle();
    int quiet = 0;
    int cyc   = 0;
    while (quiet < 4 && cyc < 500) begin
      tick();
      cyc++;
      if (!busy && sb_q.size() == 0) quiet++;
      else quiet = 0;
    end
    check("idle_reached", 32'(quiet >= 4), 1);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    tick();
  endtask

  // Monitor: measures each pulse run and its preceding low gap, checks on done.
  initial begin : monitor
    logic               prev_pulse;
    int                 run_len;
    int                 run_gap;
    int                 low_cnt;
    int                 obs_len;
    int                 obs_gap;
    logic [NUM_REQ-1:0] run_own;
    exp_t               e;
    prev_pulse = 1'b0; run_len = 0; run_gap = -1; low_cnt = 0; run_own = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_pulse = 1'b0; run_len = 0; run_gap = -1; low_cnt = 0;
      end else begin
        if (pulse && !prev_pulse) begin
          run_gap = low_cnt; run_len = 1; run_own = grant; low_cnt = 0;
        end else if (pulse) begin
          run_len++;
        end
        if (pulse) begin
          if (grant !== run_own || !$onehot(grant)) gnt_err++;
        end else begin
          if (grant !== '0) gnt_err++;
          low_cnt++;
        end
        if (done !== '0) begin
          obs_len = (prev_pulse && !pulse) ? run_len : 0;
          obs_gap = (obs_len != 0) ? run_gap : -1;
          if (sb_q.size() == 0) begin
            check("sb_unexpected_done", 32'(done), 0);
          end else begin
            e = sb_q.pop_front();
            check("sb_owner", 32'(done), 32'(1 << e.id));
            check("sb_width", 32'(obs_len), 32'(e.len));
            if (e.gap >= 0) check("sb_gap", 32'(obs_gap), 32'(e.gap));
          end
        end
        prev_pulse = pulse;
      end
    end
  end

  initial begin : stimulus
    rst = 1'b0;
    req = '0;
    width = '0;
    tick(3);
    check("rst_pulse", 32'(pulse), 0);
    check("rst_grant", 32'(grant), 0);
    check("rst_done",  32'(done), 0);
    check("rst_busy",  32'(busy), 0);
    rst = 1'b1;
    tick();
    check("post_rst_pulse", 32'(pulse), 0);

    // Single request, width 10: latency, exact width, busy through guard.
    set_w(0, 10);
    expect_pulse(0, 10, -1);
    req[0] = 1'b1;
    tick();
    check("s1_pending_only", 32'(pulse), 0);
    tick();
    check("s1_pulse_start", 32'(pulse), 1);
    check("s1_grant", 32'(grant), 32'h1);
    check("s1_busy", 32'(busy), 1);
    tick(9);
    check("s1_pulse_last", 32'(pulse), 1);
    tick();
    check("s1_pulse_end", 32'(pulse), 0);
    check("s1_done", 32'(done), 32'h1);
    tick();
    check("s1_done_single", 32'(done), 0);
    check("s1_busy_guard", 32'(busy), 1);
    tick();
    check("s1_busy_off", 32'(busy), 0);
    req[0] = 1'b0;
    wait_idle();

    // Width 0: done strobe only, no pulse, busy never rises.
    set_w(1, 0);
    expect_pulse(1, 0, -1);
    req[1] = 1'b1;
    tick();
    check("w0_busy_a", 32'(busy), 0);
    check("w0_done_a", 32'(done), 0);
    tick();
    check("w0_busy_b", 32'(busy), 0);
    check("w0_done_b", 32'(done), 32'h2);
    check("w0_no_pulse", 32'(pulse), 0);
    tick();
    check("w0_busy_c", 32'(busy), 0);
    check("w0_done_c", 32'(done), 0);
    req[1] = 1'b0;
    wait_idle();

    // Fairness: pointer now 2, requests {0,3} -> 3 before 0.
    set_w(3, 3);
    set_w(0, 2);
    expect_pulse(3, 3, -1);
    expect_pulse(0, 2, GAP);
    req[0] = 1'b1;
    req[3] = 1'b1;
    wait_idle();
    req = '0;
    tick();

    // Simultaneous from a fresh pointer, then wrap back to requester 0.
    do_reset();
    set_w(0, 3); set_w(1, 4); set_w(2, 5); set_w(3, 6);
    expect_pulse(0, 3, -1);
    expect_pulse(1, 4, GAP);
    expect_pulse(2, 5, GAP);
    expect_pulse(3, 6, GAP);
    req = 4'b1111;
    wait_idle();
    req = '0;
    tick();
    expect_pulse(0, 3, -1);
    expect_pulse(1, 4, GAP);
    req[1] = 1'b1;
    req[0] = 1'b1;
    wait_idle();
    req = '0;
    tick();

    // Three rises of req[2] during requester 3's pulse merge into one.
    set_w(3, 12);
    set_w(2, 5);
    expect_pulse(3, 12, -1);
    expect_pulse(2, 5, GAP);
    req[3] = 1'b1;
    tick(3);
    repeat (3) begin
      req[2] = 1'b1;
      tick();
      req[2] = 1'b0;
      tick();
    end
    wait_idle();
    req[3] = 1'b0;
    tick();

    // Owner retrigger during its own pulse: no extension, second pulse after guard.
    set_w(2, 8);
    expect_pulse(2, 8, -1);
    expect_pulse(2, 8, GAP);
    req[2] = 1'b1;
    tick(4);
    req[2] = 1'b0;
    tick();
    req[2] = 1'b1;
    tick();
    wait_idle();
    req[2] = 1'b0;
    tick();

    // Width changed mid-pulse is ignored.
    set_w(0, 10);
    expect_pulse(0, 10, -1);
    req[0] = 1'b1;
    tick(3);
    set_w(0, 3);
    wait_idle();
    req[0] = 1'b0;
    set_w(0, 10);
    tick();

    // Async reset in the 3rd pulse cycle, then restart with req held high.
    req[0] = 1'b1;
    tick(2);
    tick(2);
    check("ar_pulse_before", 32'(pulse), 1);
    rst = 1'b0;
    #1;
    check("ar_pulse", 32'(pulse), 0);
    check("ar_grant", 32'(grant), 0);
    check("ar_busy",  32'(busy), 0);
    tick();
    expect_pulse(0, 10, -1);
    rst = 1'b1;
    tick();
    check("ar_restart_wait", 32'(pulse), 0);
    tick();
    check("ar_restart_pulse", 32'(pulse), 1);
    check("ar_restart_grant", 32'(grant), 32'h1);
    wait_idle();
    req = '0;
    tick(2);

    check("sb_drained", 32'(sb_q.size()), 0);
    check("grant_consistency", 32'(gnt_err), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
